// File: rtl/mem_access_ctl_pkg.sv
// Shared definitions for the memory access controller: default widths and FSM state encoding.
package mem_access_ctl_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int RAM_SIZE_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    PTR,
    PTR_W,
    RD,
    RD_W,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mem_access_ctl.sv
// Single-request controller for an external synchronous RAM; supports direct and
// pointer-indirect reads and writes, with an error flag for out-of-range pointers.
module mem_access_ctl
  import mem_access_ctl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RAM_SIZE = RAM_SIZE_DEF,
  parameter int ADDR_W   = $clog2(RAM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              op_wr,
  input  logic              indirect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din
);

  state_t              state, next_state;
  logic                op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ptr_bad;

  // A pointer is rejected if any bit above the address field is set or it indexes past the RAM.
  assign ptr_bad = ((ram_dout >> ADDR_W) != '0) || (int'(ram_dout) >= RAM_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (indirect)   next_state = PTR;
          else if (op_wr) next_state = WR;
          else            next_state = RD;
        end
      end
      PTR:   next_state = PTR_W;
      PTR_W: begin
        if (ptr_bad)   next_state = DONE;
        else if (op_q) next_state = WR;
        else           next_state = RD;
      end
      RD:    next_state = RD_W;
      RD_W:  next_state = DONE;
      WR:    next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ack       = (state == DONE);
    err       = (state == DONE) && err_q;
    ram_we    = (state == WR);
    ram_waddr = addr_q;
    ram_din   = wdata_q;
    ram_raddr = addr_q;
    rdata     = rdata_q;
  end

  // Request fields are captured once in IDLE; addr_q is later replaced by the dereferenced pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= op_wr;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        PTR_W: begin
          if (ptr_bad) err_q  <= 1'b1;
          else         addr_q <= ram_dout[ADDR_W-1:0];
        end
        RD_W:    rdata_q <= ram_dout;
        DONE:    err_q   <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Self-checking bench for mem_access_ctl: transaction-level reference model with a
// per-cycle compare process, directed scenarios, then randomized traffic.
module tb_mem_access_ctl;

  localparam int DW = 8;
  localparam int RS = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          op_wr = 1'b0;
  logic          indirect = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, ack, err, ram_we;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_raddr, ram_waddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctl #(.DATA_W(DW), .RAM_SIZE(RS), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_wr(op_wr), .indirect(indirect),
    .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_din(ram_din)
  );

  // Attached RAM: registered read, synchronous write.
  logic [DW-1:0] phys_mem [RS];
  always @(posedge clk) begin
    if (ram_we) phys_mem[ram_waddr] <= ram_din;
    ram_dout <= phys_mem[ram_raddr];
  end

  int we_count = 0;
  int ack_count = 0;
  always @(negedge clk) begin
    if (ram_we) we_count++;
    if (ack)    ack_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, expectations derived from the latency table and pointer rule.
  logic [DW-1:0] model_mem [RS];
  int            cyc = 0;
  int            start_cyc = -10;
  int            ack_cyc = -10;
  int            we_cyc = -10;
  logic [AW-1:0] we_addr = '0;
  logic [DW-1:0] we_data = '0;
  logic [AW-1:0] exp_raddr = '0;
  logic [DW-1:0] pend_val = '0;
  logic [DW-1:0] cur_rdata = '0;
  bit            pend_rd = 1'b0;
  bit            exp_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int            lat;
    logic [DW-1:0] ptr;
    logic [AW-1:0] eff;
    bit            bad;
    if (!rst_n) begin
      start_cyc = -10;
      ack_cyc   = -10;
      we_cyc    = -10;
      pend_rd   = 1'b0;
      cur_rdata = '0;
    end else begin
      if (cyc == we_cyc) model_mem[we_addr] = we_data;
      if (req && cyc > ack_cyc) begin
        bad = 1'b0;
        eff = addr;
        if (indirect) begin
          ptr = model_mem[addr];
          if (int'(ptr) >= RS) bad = 1'b1;
          else                 eff = ptr[AW-1:0];
        end
        if (bad)        lat = 3;
        else if (op_wr) lat = indirect ? 4 : 2;
        else            lat = indirect ? 5 : 3;
        start_cyc = cyc + 1;
        ack_cyc   = cyc + lat;
        exp_err   = bad;
        exp_raddr = bad ? addr : eff;
        pend_rd   = !bad && !op_wr;
        pend_val  = model_mem[eff];
        we_cyc    = (!bad && op_wr) ? cyc + lat - 1 : -10;
        we_addr   = eff;
        we_data   = wdata;
      end
      cyc++;
      if (cyc == ack_cyc && pend_rd) cur_rdata = pend_val;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      checkOutput("busy", 32'(busy), 32'(cyc >= start_cyc && cyc <= ack_cyc));
      checkOutput("ack", 32'(ack), 32'(cyc == ack_cyc));
      checkOutput("ram_we", 32'(ram_we), 32'(cyc == we_cyc));
      checkOutput("rdata", 32'(rdata), 32'(cur_rdata));
      if (cyc == ack_cyc) begin
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("ram_raddr_at_ack", 32'(ram_raddr), 32'(exp_raddr));
      end
      if (cyc == we_cyc) begin
        checkOutput("ram_waddr", 32'(ram_waddr), 32'(we_addr));
        checkOutput("ram_din", 32'(ram_din), 32'(we_data));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic wr, input logic ind,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    req = r; op_wr = wr; indirect = ind; addr = a; wdata = d;
  endtask

  task automatic doAccess(input logic wr, input logic ind, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output logic e);
    applyStimulus(1'b1, wr, ind, a, d);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    lat = 0;
    e   = 1'b0;
    while (lat < 20) begin
      if (lat > 0 || 1'b1) @(negedge clk);
      lat++;
      if (ack) begin
        e = err;
        break;
      end
    end
    if (!ack) checkOutput("ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    int          lat;
    logic        e;
    int          acks, idles, ack0, we0;
    logic [DW-1:0] v;

    for (int i = 0; i < RS; i++) begin
      v = ($urandom % 4 == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      phys_mem[i]  = v;
      model_mem[i] = v;
    end
    phys_mem[7] = 8'h0C;  model_mem[7] = 8'h0C;
    phys_mem[12] = 8'h33; model_mem[12] = 8'h33;
    phys_mem[5] = 8'h21;  model_mem[5] = 8'h21;

    #1;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_ack", 32'(ack), 32'(0));
    checkOutput("reset_ram_we", 32'(ram_we), 32'(0));
    checkOutput("reset_rdata", 32'(rdata), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Direct write then read-back of the same word.
    doAccess(1'b1, 1'b0, 5'd3, 8'h5A, lat, e);
    checkOutput("dir_wr_latency", 32'(lat), 32'(2));
    doAccess(1'b0, 1'b0, 5'd3, 8'h00, lat, e);
    checkOutput("dir_rd_latency", 32'(lat), 32'(3));
    checkOutput("dir_rd_rdata", 32'(rdata), 32'(8'h5A));
    checkOutput("dir_rd_err", 32'(e), 32'(0));

    // Indirect read through mem[7]=0x0C to mem[12]=0x33.
    doAccess(1'b0, 1'b1, 5'd7, 8'h00, lat, e);
    checkOutput("ind_rd_latency", 32'(lat), 32'(5));
    checkOutput("ind_rd_rdata", 32'(rdata), 32'(8'h33));

    // Out-of-range pointer: no RAM write, rdata keeps the previous read.
    doAccess(1'b1, 1'b0, 5'd7, 8'h40, lat, e);
    we0 = we_count;
    doAccess(1'b1, 1'b1, 5'd7, 8'hFF, lat, e);
    checkOutput("ptr_err_flag", 32'(e), 32'(1));
    checkOutput("ptr_err_latency", 32'(lat), 32'(3));
    checkOutput("ptr_err_no_we", 32'(we_count - we0), 32'(0));
    checkOutput("ptr_err_rdata", 32'(rdata), 32'(8'h33));

    // Continuous req with direct reads: one access every 4 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd3, 8'h00);
    @(posedge clk);
    acks = 0;
    idles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack)   acks++;
      if (!busy) idles++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    waitIdle();
    checkOutput("b2b_acks", 32'(acks), 32'(5));
    checkOutput("b2b_idle_cycles", 32'(idles), 32'(5));

    // Requests while busy (including in DONE) are dropped.
    ack0 = ack_count;
    we0  = we_count;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd3, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 8'h77);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    checkOutput("busy_req_acks", 32'(ack_count - ack0), 32'(1));
    checkOutput("busy_req_no_we", 32'(we_count - we0), 32'(0));

    // Reset asserted in the WR cycle of a write of 0x11 to addr 5.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("wr_cycle_we", 32'(ram_we), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_we_drop", 32'(ram_we), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    ack0 = ack_count;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rst_no_ack", 32'(ack_count - ack0), 32'(0));
    checkOutput("rst_mem5_kept", 32'(phys_mem[5]), 32'(8'h21));

    // Randomized traffic, including requests while busy.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom % 3 == 0), 1'($urandom % 2), 1'($urandom % 2),
                    5'($urandom_range(0, 31)),
                    ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
